pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 42 ++++
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/pipe_dmem_fsm.sv | 86 ++++++++
 rtl/pipe_hazard_ctrl.sv | 92 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared constants and types for the pipeline stall/flush sequencer:
//   - writeback-source encoding that marks a load (WD_RAM)
//   - bit positions inside the susp / flush vectors
//   - DMEM handshake FSM state encodings
//   - packed control bundle and a source-operand hazard helper
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    // ex_wd_sel value that selects data memory as the writeback source
    localparam logic [1:0] WD_RAM = 2'b01;

    // susp = {ex_mem, id_ex, if_id, pc}
    localparam int SUSP_PC     = 0;
    localparam int SUSP_IF_ID  = 1;
    localparam int SUSP_ID_EX  = 2;
    localparam int SUSP_EX_MEM = 3;

    // flush = {id_ex, if_id}
    localparam int FLUSH_IF_ID = 0;
    localparam int FLUSH_ID_EX = 1;

    // DMEM FSM state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef struct packed {
        logic [3:0] susp;
        logic [1:0] flush;
        logic       wb_bubble;
    } hz_ctrl_t;

    // True when a used source operand matches a non-zero destination.
    // x0 is hardwired to zero, so it can never carry a real dependency.
    function automatic logic src_hit(input logic       used,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
        return used && (rs == rd) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives ID/EX/MEM status and dmem_ack,
//            receives stall/flush controls and debug status
//   slave  : hazard controller side (mirror directions)
// Signals:
//   id_rs1/id_rs1_used/id_rs2/id_rs2_used/id_valid  ID-stage operand info
//   ex_valid/ex_wR/ex_rf_we/ex_wd_sel/ex_redirect   EX-stage info
//   mem_valid/mem_acc/dmem_ack                      MEM-stage access handshake
//   dmem_req, susp[3:0], flush[1:0], wb_bubble      controls
//   dmem_err, stall_cnt[CNT_W-1:0]                  debug status
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic             id_rs1_used;
    logic [4:0]       id_rs2;
    logic             id_rs2_used;
    logic             id_valid;
    logic             ex_valid;
    logic [4:0]       ex_wR;
    logic             ex_rf_we;
    logic [1:0]       ex_wd_sel;
    logic             ex_redirect;
    logic             mem_valid;
    logic             mem_acc;
    logic             dmem_ack;
    logic             dmem_req;
    logic [3:0]       susp;
    logic [1:0]       flush;
    logic             wb_bubble;
    logic             dmem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_valid,
        output ex_valid, ex_wR, ex_rf_we, ex_wd_sel, ex_redirect,
        output mem_valid, mem_acc, dmem_ack,
        input  dmem_req, susp, flush, wb_bubble, dmem_err, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_valid,
        input  ex_valid, ex_wR, ex_rf_we, ex_wd_sel, ex_redirect,
        input  mem_valid, mem_acc, dmem_ack,
        output dmem_req, susp, flush, wb_bubble, dmem_err, stall_cnt
    );

endinterface

// File: rtl/pipe_dmem_fsm.sv
// -----------------------------------------------------------------------------
// pipe_dmem_fsm
// Variable-latency data-memory handshake for the MEM stage.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no access outstanding; request follows mem_valid & mem_acc
//   WAIT    | access issued, no ack yet; request held, tmo_cnt counts cycles
//
// Ports:
//   i_clk, i_rst   clock / synchronous active-high reset
//   i_mem_valid    MEM holds a real instruction
//   i_mem_acc      MEM instruction is a load or store
//   i_dmem_ack     memory completes the access this cycle
//   o_dmem_req     request to data memory (forced 0 during reset)
//   o_mem_busy     MEM cannot complete this cycle; pipeline must freeze
//   o_dmem_err     sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module pipe_dmem_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_mem_valid,
    input  logic i_mem_acc,
    input  logic i_dmem_ack,
    output logic o_dmem_req,
    output logic o_mem_busy,
    output logic o_dmem_err
);

    localparam int              TMO_W    = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DMEM_TIMEOUT);

    logic [0:0]       r_state;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_dmem_err;

    logic w_req;
    logic w_tmo_hit;

    // In WAIT the MEM stage is frozen, so the request is held regardless of
    // what mem_valid/mem_acc show.
    always_comb begin
        w_req = 1'b0;
        if (!i_rst) begin
            if (r_state == ST_WAIT) begin
                w_req = 1'b1;
            end else begin
                w_req = i_mem_valid & i_mem_acc;
            end
        end
    end

    // The final WAIT cycle completes as if acked, so it must not stall.
    assign w_tmo_hit  = (r_state == ST_WAIT) && (r_tmo_cnt == TMO_LAST);
    assign o_mem_busy = w_req & ~i_dmem_ack & ~w_tmo_hit;
    assign o_dmem_req = w_req;
    assign o_dmem_err = r_dmem_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_tmo_cnt  <= '0;
            r_dmem_err <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_req && !i_dmem_ack) begin
                r_state   <= ST_WAIT;
                r_tmo_cnt <= TMO_W'(1);
            end
        end else begin
            if (i_dmem_ack || w_tmo_hit) begin
                r_state   <= ST_IDLE;
                r_tmo_cnt <= '0;
                if (!i_dmem_ack) begin
                    r_dmem_err <= 1'b1;
                end
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline
// (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// Ports:
//   i_cpu_clk   clock, all state updates on posedge
//   i_cpu_rst   synchronous reset, active-high; forces all controls to 0
//   bus         pipe_hazard_ctrl_if.slave (see interface header)
//
// Per-cycle priority (exactly one applies):
//   1 MEM busy      : freeze PC..EX/MEM, bubble into MEM/WB
//   2 EX redirect   : flush IF/ID and ID/EX
//   3 load-use      : hold PC and IF/ID, bubble into ID/EX
//   4 otherwise     : advance
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic               i_cpu_clk,
    input  logic               i_cpu_rst,
    pipe_hazard_ctrl_if.slave  bus
);

    logic             w_mem_busy;
    logic             w_dmem_req;
    logic             w_dmem_err;
    logic             w_load_use;
    logic             w_redirect;
    hz_ctrl_t         w_ctrl;
    logic [CNT_W-1:0] r_stall_cnt;

    pipe_dmem_fsm #(
        .DMEM_TIMEOUT (DMEM_TIMEOUT)
    ) u_dmem_fsm (
        .i_clk       (i_cpu_clk),
        .i_rst       (i_cpu_rst),
        .i_mem_valid (bus.mem_valid),
        .i_mem_acc   (bus.mem_acc),
        .i_dmem_ack  (bus.dmem_ack),
        .o_dmem_req  (w_dmem_req),
        .o_mem_busy  (w_mem_busy),
        .o_dmem_err  (w_dmem_err)
    );

    assign w_load_use = bus.ex_valid & bus.ex_rf_we
                      & (bus.ex_wd_sel == WD_RAM)
                      & bus.id_valid
                      & (src_hit(bus.id_rs1_used, bus.id_rs1, bus.ex_wR)
                       | src_hit(bus.id_rs2_used, bus.id_rs2, bus.ex_wR));

    assign w_redirect = bus.ex_redirect & bus.ex_valid;

    // While frozen, EX and ID are held, so redirect and load-use are simply
    // re-evaluated on the first advancing cycle. Redirect beats load-use
    // because the dependent ID instruction is squashed anyway.
    always_comb begin
        w_ctrl = '0;
        if (!i_cpu_rst) begin
            if (w_mem_busy) begin
                w_ctrl.susp      = 4'b1111;
                w_ctrl.wb_bubble = 1'b1;
            end else if (w_redirect) begin
                w_ctrl.flush[FLUSH_IF_ID] = 1'b1;
                w_ctrl.flush[FLUSH_ID_EX] = 1'b1;
            end else if (w_load_use) begin
                w_ctrl.susp[SUSP_PC]      = 1'b1;
                w_ctrl.susp[SUSP_IF_ID]   = 1'b1;
                w_ctrl.flush[FLUSH_ID_EX] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_cpu_clk) begin
        if (i_cpu_rst) begin
            r_stall_cnt <= '0;
        end else if ((|w_ctrl.susp) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.dmem_req  = w_dmem_req;
    assign bus.susp      = w_ctrl.susp;
    assign bus.flush     = w_ctrl.flush;
    assign bus.wb_bubble = w_ctrl.wb_bubble;
    assign bus.dmem_err  = w_dmem_err;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl with DMEM_TIMEOUT=4.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipe_hazard_ctrl #(
        .DMEM_TIMEOUT (4),
        .CNT_W        (32)
    ) dut (
        .i_cpu_clk (clk),
        .i_cpu_rst (rst),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs1      = 5'd0;
        bus.id_rs1_used = 1'b0;
        bus.id_rs2      = 5'd0;
        bus.id_rs2_used = 1'b0;
        bus.id_valid    = 1'b0;
        bus.ex_valid    = 1'b0;
        bus.ex_wR       = 5'd0;
        bus.ex_rf_we    = 1'b0;
        bus.ex_wd_sel   = 2'b00;
        bus.ex_redirect = 1'b0;
        bus.mem_valid   = 1'b0;
        bus.mem_acc     = 1'b0;
        bus.dmem_ack    = 1'b0;
    endtask

    // ex: lw x5 ; id: add x6, x5, x7
    task automatic set_load_use();
        bus.ex_valid    = 1'b1;
        bus.ex_rf_we    = 1'b1;
        bus.ex_wd_sel   = WD_RAM;
        bus.ex_wR       = 5'd5;
        bus.id_valid    = 1'b1;
        bus.id_rs1      = 5'd5;
        bus.id_rs1_used = 1'b1;
        bus.id_rs2      = 5'd7;
        bus.id_rs2_used = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        // Reset forces combinational outputs low even with active requests
        bus.mem_valid   = 1'b1;
        bus.mem_acc     = 1'b1;
        bus.ex_valid    = 1'b1;
        bus.ex_redirect = 1'b1;
        #1;
        chk("rst_req", 64'(bus.dmem_req), 64'd0);
        chk("rst_susp", 64'(bus.susp), 64'd0);
        chk("rst_flush", 64'(bus.flush), 64'd0);
        tick();
        chk("rst_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rst_err", 64'(bus.dmem_err), 64'd0);
        idle_inputs();
        rst = 1'b0;
        tick();
        chk("idle_req", 64'(bus.dmem_req), 64'd0);

        // 1: zero-wait store
        bus.mem_valid = 1'b1; bus.mem_acc = 1'b1; bus.dmem_ack = 1'b1;
        #1;
        chk("zw_req", 64'(bus.dmem_req), 64'd1);
        chk("zw_susp", 64'(bus.susp), 64'd0);
        chk("zw_bub", 64'(bus.wb_bubble), 64'd0);
        tick();
        // back-to-back access, requested immediately
        chk("b2b_req", 64'(bus.dmem_req), 64'd1);
        chk("b2b_susp", 64'(bus.susp), 64'd0);
        tick();
        idle_inputs();
        #1;
        chk("zw_idle_req", 64'(bus.dmem_req), 64'd0);
        chk("zw_cnt", 64'(bus.stall_cnt), 64'd0);

        // 2: 3-cycle load, ack in cycle 3
        bus.mem_valid = 1'b1; bus.mem_acc = 1'b1;
        #1;
        chk("ld_c1_susp", 64'(bus.susp), 64'hF);
        chk("ld_c1_bub", 64'(bus.wb_bubble), 64'd1);
        tick();
        chk("ld_c2_susp", 64'(bus.susp), 64'hF);
        chk("ld_c2_req", 64'(bus.dmem_req), 64'd1);
        tick();
        bus.dmem_ack = 1'b1;
        #1;
        chk("ld_c3_susp", 64'(bus.susp), 64'd0);
        chk("ld_c3_bub", 64'(bus.wb_bubble), 64'd0);
        chk("ld_c3_req", 64'(bus.dmem_req), 64'd1);
        tick();
        idle_inputs();
        #1;
        chk("ld_done_req", 64'(bus.dmem_req), 64'd0);
        chk("ld_cnt", 64'(bus.stall_cnt), 64'd2);

        // 3: load-use
        set_load_use();
        #1;
        chk("lu_rs1_susp", 64'(bus.susp), 64'h3);
        chk("lu_rs1_flush", 64'(bus.flush), 64'h2);
        chk("lu_rs1_bub", 64'(bus.wb_bubble), 64'd0);
        tick();
        chk("lu_cnt", 64'(bus.stall_cnt), 64'd3);
        bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd5;
        #1;
        chk("lu_rs2_susp", 64'(bus.susp), 64'h3);
        tick();
        bus.id_rs2_used = 1'b0;
        #1;
        chk("lu_unused_susp", 64'(bus.susp), 64'h0);
        bus.id_rs2_used = 1'b1; bus.ex_wd_sel = 2'b00;
        #1;
        chk("lu_alu_susp", 64'(bus.susp), 64'h0);
        set_load_use();
        bus.ex_wR = 5'd0; bus.id_rs1 = 5'd0;
        #1;
        chk("lu_x0_susp", 64'(bus.susp), 64'h0);
        chk("lu_x0_flush", 64'(bus.flush), 64'h0);
        set_load_use();
        bus.id_valid = 1'b0;
        #1;
        chk("lu_idinv_susp", 64'(bus.susp), 64'h0);
        tick();
        chk("lu_cnt2", 64'(bus.stall_cnt), 64'd4);

        // 4: redirect beats load-use; redirect held off by mem_busy
        set_load_use();
        bus.ex_redirect = 1'b1;
        #1;
        chk("rd_lu_susp", 64'(bus.susp), 64'h0);
        chk("rd_lu_flush", 64'(bus.flush), 64'h3);
        bus.mem_valid = 1'b1; bus.mem_acc = 1'b1;
        #1;
        chk("rd_busy_susp", 64'(bus.susp), 64'hF);
        chk("rd_busy_flush", 64'(bus.flush), 64'h0);
        tick();
        bus.dmem_ack = 1'b1;
        #1;
        chk("rd_ack_susp", 64'(bus.susp), 64'h0);
        chk("rd_ack_flush", 64'(bus.flush), 64'h3);
        tick();
        idle_inputs();
        #1;
        chk("rd_cnt", 64'(bus.stall_cnt), 64'd5);

        // 5: timeout with DMEM_TIMEOUT=4, no ack ever
        bus.mem_valid = 1'b1; bus.mem_acc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("to_req_%0d", i), 64'(bus.dmem_req), 64'd1);
            chk($sformatf("to_susp_%0d", i), 64'(bus.susp), (i < 4) ? 64'hF : 64'h0);
            chk($sformatf("to_err_%0d", i), 64'(bus.dmem_err), 64'd0);
            tick();
        end
        idle_inputs();
        #1;
        chk("to_after_req", 64'(bus.dmem_req), 64'd0);
        chk("to_after_err", 64'(bus.dmem_err), 64'd1);
        chk("to_cnt", 64'(bus.stall_cnt), 64'd9);
        tick();
        tick();
        chk("to_err_sticky", 64'(bus.dmem_err), 64'd1);

        // 6: reset while in WAIT
        bus.mem_valid = 1'b1; bus.mem_acc = 1'b1;
        tick();
        chk("rw_wait_susp", 64'(bus.susp), 64'hF);
        rst = 1'b1;
        #1;
        chk("rw_rst_req", 64'(bus.dmem_req), 64'd0);
        chk("rw_rst_susp", 64'(bus.susp), 64'h0);
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rw_req", 64'(bus.dmem_req), 64'd0);
        chk("rw_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rw_err", 64'(bus.dmem_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
